// File: rtl/cpu_pkg.sv
// Shared CPU types and constants.
// Used by fetch and decode stages.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between fetch and decode.
// Flush drops every entry; reset also zeroes storage.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           din,
    input  logic                   pop,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [AW:0]    cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            mem    <= '{default: '0};
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    assign head  = mem[rd_ptr];
    assign count = cnt;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC sequencing, credit-based issue to RAM,
// and a small buffer presented to decode via valid/ready.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_VECTOR,
    parameter logic [XLEN-1:0] PC_STEP  = cpu_pkg::PC_STEP,
    parameter int              DEPTH    = 2
) (
    input  logic            clock,
    input  logic            reset,
    output logic [XLEN-1:0] pc_addr,
    input  logic [XLEN-1:0] pc_q,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic            req_v;
    logic            pop;
    logic            issue;
    logic [CW:0]     credit;
    logic [CW-1:0]   count;
    fetch_entry_t    head;
    fetch_entry_t    cap;

    assign pop = instr_valid & instr_ready & ~redirect;

    // Entries already buffered plus the one in flight must fit.
    assign credit = {1'b0, count} + {{CW{1'b0}}, req_v}
                  - {{CW{1'b0}}, pop};
    assign issue  = ~redirect & (credit < DEPTH_C);

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            req_v    <= 1'b0;
        end else if (redirect) begin
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            req_v    <= 1'b0;
        end else if (issue) begin
            req_v    <= 1'b1;
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + PC_STEP;
        end else begin
            req_v    <= 1'b0;
        end
    end

    assign cap.instr = pc_q;
    assign cap.pc    = req_pc;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (redirect),
        .push  (req_v),
        .din   (cap),
        .pop   (pop),
        .head  (head),
        .count (count)
    );

    assign pc_addr     = fetch_pc;
    assign instr_valid = (count != '0);
    assign instr       = head.instr;
    assign instr_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios
// plus random ready/redirect/reset against a PC-stream model.
module tb_fetch_unit;

    logic        clock;
    logic        reset;
    logic [31:0] pc_addr;
    logic [31:0] pc_q;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int checks = 0;
    int errors = 0;

    // Model: the architectural PC the next delivered word must carry.
    logic [31:0] exp_pc;
    int          idle;
    logic        prev_pop;

    fetch_unit dut (
        .clock       (clock),
        .reset       (reset),
        .pc_addr     (pc_addr),
        .pc_q        (pc_q),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h11;
            32'h4:   return 32'h22;
            32'h8:   return 32'h33;
            default: return a ^ 32'hC0DE_0000;
        endcase
    endfunction

    always @(posedge clock) pc_q <= ram_word(pc_addr);

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Runs with this cycle's inputs already applied, then advances.
    task automatic observe();
        if (prev_pop) check("stream", {31'd0, instr_valid}, 32'd1);
        check("live", {31'd0, idle <= 2}, 32'd1);
        if (instr_valid === 1'b1) begin
            check("head_pc", instr_pc, exp_pc);
            check("head_instr", instr, ram_word(exp_pc));
        end
        prev_pop = 1'b0;
        if (reset) begin
            exp_pc = 32'h0;
            idle   = 0;
        end else if (redirect) begin
            exp_pc = redirect_pc & 32'hFFFF_FFFC;
            idle   = 0;
        end else begin
            if (instr_valid !== 1'b1) idle++;
            else idle = 0;
            if (instr_valid === 1'b1 && instr_ready) begin
                exp_pc   = exp_pc + 32'd4;
                prev_pop = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        observe();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        redirect = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b1;
        exp_pc      = '0;
        idle        = 0;
        prev_pop    = 1'b0;
        @(posedge clock);
        #1;

        // Reset state and sequential stream
        do_reset();
        reset = 1'b1;
        check("rst_pc_addr", pc_addr, 32'h0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        reset = 1'b0;
        check("c0_pc_addr", pc_addr, 32'h0);
        check("c0_valid", {31'd0, instr_valid}, 32'd0);
        cycle();
        check("c1_pc_addr", pc_addr, 32'h4);
        cycle();
        check("c2_pc_addr", pc_addr, 32'h8);
        check("c2_valid", {31'd0, instr_valid}, 32'd1);
        check("c2_instr", instr, 32'h11);
        check("c2_pc", instr_pc, 32'h0);
        cycle();
        check("c3_instr", instr, 32'h22);
        check("c3_pc", instr_pc, 32'h4);
        cycle();
        check("c4_instr", instr, 32'h33);
        check("c4_pc", instr_pc, 32'h8);
        cycle();

        // Back-pressure from C2
        do_reset();
        cycle();
        cycle();
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_instr", instr, 32'h11);
            check("bp_pc_addr", pc_addr, 32'h8);
            cycle();
        end
        instr_ready = 1'b1;
        check("bp_r0", instr, 32'h11);
        cycle();
        check("bp_r1", instr, 32'h22);
        cycle();
        check("bp_r2", instr, 32'h33);
        cycle();

        // Redirect to 0x43 in cycle 5
        do_reset();
        for (int i = 0; i < 5; i++) cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h43;
        cycle();
        redirect = 1'b0;
        check("rd_pc_addr", pc_addr, 32'h40);
        check("rd_valid", {31'd0, instr_valid}, 32'd0);
        cycle();
        cycle();
        check("rd3_valid", {31'd0, instr_valid}, 32'd1);
        check("rd3_pc", instr_pc, 32'h40);
        cycle();

        // Redirect with simultaneous pop on a full FIFO
        do_reset();
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        cycle();
        redirect = 1'b0;
        check("rp_empty", {31'd0, instr_valid}, 32'd0);
        cycle();
        check("rp_empty2", {31'd0, instr_valid}, 32'd0);
        cycle();
        check("rp_pc", instr_pc, 32'h100);
        cycle();

        // Address wrap
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        cycle();
        redirect = 1'b0;
        check("wr_a0", pc_addr, 32'hFFFF_FFFC);
        cycle();
        check("wr_a1", pc_addr, 32'h0);
        cycle();
        check("wr_p0", instr_pc, 32'hFFFF_FFFC);
        cycle();
        check("wr_p1", instr_pc, 32'h0);
        cycle();

        // Reset mid-stream overrides redirect
        cycle();
        reset       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        cycle();
        reset    = 1'b0;
        redirect = 1'b0;
        check("mr_pc_addr", pc_addr, 32'h0);
        check("mr_valid", {31'd0, instr_valid}, 32'd0);
        check("mr_instr", instr, 32'h0);
        cycle();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            instr_ready = ($urandom % 4) != 0;
            redirect    = ($urandom % 16) == 0;
            redirect_pc = $urandom;
            reset       = ($urandom % 300) == 0;
            cycle();
        end
        reset    = 1'b0;
        redirect = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
